eth_rx_frame_parser: RTL and testbench



---
 rtl/eth_rx_frame_parser.sv | 274 +++++++++++++++++++++++++++
 tb/tb_eth_rx_frame_parser.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_parser.sv
//-----------------------------------------------------------------------------
// eth_rx_frame_parser
//
// Receive-side Ethernet framer. Consumes the byte stream delivered by the
// RGMII/GMII capture stage, strips preamble and SFD, runs the CRC-32 over
// the frame and hides the trailing FCS behind a 5-byte delay line. Bytes
// from destination MAC to the last payload byte go out on a non-stallable
// valid/last/error stream. Per-outcome saturating frame counters are kept.
//
// Ports:
//   clk_i              byte-domain RX clock
//   reset_n_i          asynchronous active-low reset
//   rx_en_i            byte strobe; every other input is sampled only when 1
//   rxd_i[7:0]         received byte
//   rx_dv_i            data valid
//   rx_er_i            receive error
//   m_data_o[7:0]      output byte
//   m_valid_o          one-cycle pulse per output byte (no backpressure)
//   m_last_o           final byte of the frame, qualified by m_valid_o
//   m_error_o          frame is bad, meaningful only with m_last_o
//   frames_ok_o        good frames (saturating)
//   frames_crc_err_o   frames with FCS mismatch (saturating)
//   frames_bad_o       runt / oversize / rx_er / aborted frames (saturating)
//-----------------------------------------------------------------------------
module eth_rx_frame_parser #(
    parameter int unsigned max_frame_p = 1518,
    parameter int unsigned min_frame_p = 64,
    parameter int unsigned cnt_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   rx_en_i,
    input  logic [7:0]             rxd_i,
    input  logic                   rx_dv_i,
    input  logic                   rx_er_i,
    output logic [7:0]             m_data_o,
    output logic                   m_valid_o,
    output logic                   m_last_o,
    output logic                   m_error_o,
    output logic [cnt_width_p-1:0] frames_ok_o,
    output logic [cnt_width_p-1:0] frames_crc_err_o,
    output logic [cnt_width_p-1:0] frames_bad_o
);

    // Byte counter only has to reach max_frame_p: the oversize check stops
    // it there.
    localparam int unsigned len_width_lp = $clog2(max_frame_p + 1);
    localparam int          dly_depth_lp = 5;

    localparam logic [len_width_lp-1:0] max_len_lp = len_width_lp'(max_frame_p);
    localparam logic [len_width_lp-1:0] min_len_lp = len_width_lp'(min_frame_p);
    localparam logic [len_width_lp-1:0] dly_len_lp = len_width_lp'(dly_depth_lp);

    localparam logic [31:0] crc_poly_lp    = 32'hEDB88320;
    localparam logic [31:0] crc_init_lp    = 32'hFFFFFFFF;
    // Register value left after running a frame plus its own (inverted,
    // LSB-first) FCS through the reflected CRC without final inversion.
    localparam logic [31:0] crc_residue_lp = 32'hDEBB20E3;

    localparam logic [7:0] preamble_byte_lp = 8'h55;
    localparam logic [7:0] sfd_byte_lp      = 8'hD5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } state_e;

    state_e                  state_q, state_d;
    logic [31:0]             crc_q, crc_d;
    logic [len_width_lp-1:0] len_q, len_d;
    logic                    err_q, err_d;

    logic [7:0]              dly_q [dly_depth_lp];
    logic                    dly_shift;

    logic [7:0]              m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;
    logic                    m_error_q, m_error_d;

    logic [cnt_width_p-1:0]  ok_q, ok_d;
    logic [cnt_width_p-1:0]  crc_err_q, crc_err_d;
    logic [cnt_width_p-1:0]  bad_q, bad_d;

    logic                    runt;
    logic                    crc_match;
    logic                    frame_good;

    // One byte of the reflected CRC-32, LSB of the data byte first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ crc_poly_lp;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] v);
        return (&v) ? v : v + cnt_width_p'(1);
    endfunction

    assign runt       = (len_q < min_len_lp);
    assign crc_match  = (crc_q == crc_residue_lp);
    assign frame_good = crc_match && !runt && !err_q;

    //-------------------------------------------------------------------------
    // Next-state and output logic
    //-------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        crc_d     = crc_q;
        len_d     = len_q;
        err_d     = err_q;
        dly_shift = 1'b0;
        m_data_d  = m_data_q;
        m_valid_d = 1'b0;   // valid/last/error are single-cycle pulses
        m_last_d  = 1'b0;
        m_error_d = 1'b0;
        ok_d      = ok_q;
        crc_err_d = crc_err_q;
        bad_d     = bad_q;

        if (rx_en_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_dv_i) begin
                        if (rxd_i == preamble_byte_lp) begin
                            state_d = ST_PREAMBLE;
                        end else begin
                            state_d = ST_DROP;
                            bad_d   = sat_inc(bad_q);
                        end
                    end
                end

                ST_PREAMBLE: begin
                    if (!rx_dv_i) begin
                        // Carrier lost during preamble: not counted.
                        state_d = ST_IDLE;
                    end else if (rx_er_i ||
                                 ((rxd_i != preamble_byte_lp) && (rxd_i != sfd_byte_lp))) begin
                        state_d = ST_DROP;
                        bad_d   = sat_inc(bad_q);
                    end else if (rxd_i == sfd_byte_lp) begin
                        state_d = ST_DATA;
                        crc_d   = crc_init_lp;
                        len_d   = '0;
                        err_d   = 1'b0;
                    end
                end

                ST_DATA: begin
                    if (rx_dv_i) begin
                        if (len_q == max_len_lp) begin
                            // Frame too long: close it out with the oldest
                            // held byte and discard the rest of it.
                            m_data_d  = dly_q[dly_depth_lp-1];
                            m_valid_d = 1'b1;
                            m_last_d  = 1'b1;
                            m_error_d = 1'b1;
                            bad_d     = sat_inc(bad_q);
                            state_d   = ST_DROP;
                        end else begin
                            crc_d     = crc_byte(crc_q, rxd_i);
                            len_d     = len_q + len_width_lp'(1);
                            dly_shift = 1'b1;
                            if (rx_er_i) begin
                                err_d = 1'b1;
                            end
                            // Line already full: the byte falling out is
                            // payload, never FCS, because four newer bytes
                            // stay behind it.
                            if (len_q >= dly_len_lp) begin
                                m_data_d  = dly_q[dly_depth_lp-1];
                                m_valid_d = 1'b1;
                            end
                        end
                    end else begin
                        state_d = ST_IDLE;
                        // The four youngest bytes are the FCS; the oldest
                        // entry is the final payload byte.
                        if (len_q >= dly_len_lp) begin
                            m_data_d  = dly_q[dly_depth_lp-1];
                            m_valid_d = 1'b1;
                            m_last_d  = 1'b1;
                            m_error_d = !frame_good;
                        end
                        if (err_q || runt) begin
                            bad_d = sat_inc(bad_q);
                        end else if (!crc_match) begin
                            crc_err_d = sat_inc(crc_err_q);
                        end else begin
                            ok_d = sat_inc(ok_q);
                        end
                    end
                end

                ST_DROP: begin
                    if (!rx_dv_i) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    //-------------------------------------------------------------------------
    // State and output registers
    //-------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            crc_q     <= crc_init_lp;
            len_q     <= '0;
            err_q     <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_error_q <= 1'b0;
            ok_q      <= '0;
            crc_err_q <= '0;
            bad_q     <= '0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            len_q     <= len_d;
            err_q     <= err_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_error_q <= m_error_d;
            ok_q      <= ok_d;
            crc_err_q <= crc_err_d;
            bad_q     <= bad_d;
        end
    end

    // NOTE: the delay line is pure data storage; its fill level is tracked
    // by len_q, so the array needs no reset and an empty line after reset
    // is guaranteed by len_q = 0.
    always_ff @(posedge clk_i) begin
        if (dly_shift) begin
            dly_q[0] <= rxd_i;
            for (int i = 1; i < dly_depth_lp; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign m_data_o         = m_data_q;
    assign m_valid_o        = m_valid_q;
    assign m_last_o         = m_last_q;
    assign m_error_o        = m_error_q;
    assign frames_ok_o      = ok_q;
    assign frames_crc_err_o = crc_err_q;
    assign frames_bad_o     = bad_q;

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
//-----------------------------------------------------------------------------
// tb_eth_rx_frame_parser
//
// Directed bench for eth_rx_frame_parser. Frames are built as byte queues
// (payload i & 8'hFF, FCS computed here), driven through the byte strobe,
// and the output beats are collected by a monitor on the falling edge.
//-----------------------------------------------------------------------------
module tb_eth_rx_frame_parser;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rx_en;
    logic [7:0]    rxd;
    logic          rx_dv;
    logic          rx_er;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_error;
    logic [CW-1:0] frames_ok;
    logic [CW-1:0] frames_crc_err;
    logic [CW-1:0] frames_bad;

    always #5 clk = ~clk;

    eth_rx_frame_parser #(
        .max_frame_p (1518),
        .min_frame_p (64),
        .cnt_width_p (CW)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .rx_en_i          (rx_en),
        .rxd_i            (rxd),
        .rx_dv_i          (rx_dv),
        .rx_er_i          (rx_er),
        .m_data_o         (m_data),
        .m_valid_o        (m_valid),
        .m_last_o         (m_last),
        .m_error_o        (m_error),
        .frames_ok_o      (frames_ok),
        .frames_crc_err_o (frames_crc_err),
        .frames_bad_o     (frames_bad)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       err;
        int         cycle;
    } beat_t;

    beat_t      beats[$];
    logic [7:0] frm[$];
    int         cyc    = 0;
    int         pace   = 1;
    int         errors = 0;
    int         checks = 0;

    logic [CW-1:0] exp_ok  = '0;
    logic [CW-1:0] exp_crc = '0;
    logic [CW-1:0] exp_bad = '0;

    // Output monitor, half a cycle away from the active edge.
    always @(negedge clk) begin
        beat_t b;
        cyc = cyc + 1;
        if (m_valid === 1'b1) begin
            b.data  = m_data;
            b.last  = m_last;
            b.err   = m_error;
            b.cycle = cyc;
            beats.push_back(b);
        end
    end

    //-------------------------------------------------------------------------
    // Stimulus helpers
    //-------------------------------------------------------------------------
    function automatic logic [31:0] calc_crc(input int n);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            b = frm[i];
            for (int k = 0; k < 8; k++) begin
                c = (c >> 1) ^ (32'hEDB88320 & {32{c[0] ^ b[k]}});
            end
        end
        return c;
    endfunction

    // n payload bytes 00,01,..., then FCS (optionally with bit 0 of FCS byte 0 flipped).
    task automatic build_frame(input int n, input bit with_fcs, input bit corrupt);
        logic [31:0] fcs;
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'(i));
        if (with_fcs) begin
            fcs = ~calc_crc(n);
            frm.push_back(fcs[7:0] ^ (corrupt ? 8'h01 : 8'h00));
            frm.push_back(fcs[15:8]);
            frm.push_back(fcs[23:16]);
            frm.push_back(fcs[31:24]);
        end
    endtask

    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        @(negedge clk);
        rx_en = 1'b1;
        rx_dv = dv;
        rxd   = d;
        rx_er = er;
        for (int i = 1; i < pace; i++) begin
            @(negedge clk);
            rx_en = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_en = 1'b0;
            rx_dv = 1'b0;
            rxd   = 8'h00;
            rx_er = 1'b0;
        end
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
    endtask

    // Preamble, SFD, frm[], one dv=0 sample. er_idx < 0 means no rx_er.
    task automatic send_frame(input int er_idx);
        send_preamble();
        for (int i = 0; i < frm.size(); i++) drive(1'b1, frm[i], (i == er_idx));
        drive(1'b0, 8'h00, 1'b0);
    endtask

    // Number of beats in [start, start+n) whose data is not the expected
    // counting pattern or whose last flag is not set exactly on the final one.
    function automatic int seq_errs(input int start, input int n);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            if (start + i >= beats.size()) e++;
            else if (beats[start+i].data !== 8'(i) || beats[start+i].last !== (i == n - 1)) e++;
        end
        return e;
    endfunction

    function automatic logic beat_err(input int idx);
        if (idx < 0 || idx >= beats.size()) return 1'bx;
        return beats[idx].err;
    endfunction

    //-------------------------------------------------------------------------
    // Tests
    //-------------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        rx_en = 1'b0; rx_dv = 1'b0; rxd = 8'h00; rx_er = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_valid, m_last, m_error, m_data} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {m_valid, m_last, m_error, m_data});
        end
        reset_n = 1'b1;
        idle(3);
        checks++;
        if ({frames_ok, frames_crc_err, frames_bad} !== {CW*3{1'b0}}) begin
            errors++;
            $display("FAIL reset_counters: got ok=%0d crc=%0d bad=%0d expected 0/0/0",
                     frames_ok, frames_crc_err, frames_bad);
        end
        checks++;
        if (beats.size() != 0) begin
            errors++;
            $display("FAIL reset_no_beats: got %0d beats expected 0", beats.size());
        end
    endtask

    task automatic check_frame(input string name, input int n_beats, input logic exp_err);
        int se;
        checks++;
        if (beats.size() != n_beats) begin
            errors++;
            $display("FAIL %s_beats: got %0d expected %0d", name, beats.size(), n_beats);
        end
        if (n_beats > 0) begin
            se = seq_errs(0, n_beats);
            checks++;
            if (se != 0) begin
                errors++;
                $display("FAIL %s_sequence: got %0d bad beats expected 0", name, se);
            end
            checks++;
            if (beat_err(n_beats - 1) !== exp_err) begin
                errors++;
                $display("FAIL %s_last_error: got %b expected %b", name, beat_err(n_beats - 1), exp_err);
            end
        end
        checks++;
        if ({frames_ok, frames_crc_err, frames_bad} !== {exp_ok, exp_crc, exp_bad}) begin
            errors++;
            $display("FAIL %s_counters: got ok=%0d crc=%0d bad=%0d expected ok=%0d crc=%0d bad=%0d",
                     name, frames_ok, frames_crc_err, frames_bad, exp_ok, exp_crc, exp_bad);
        end
    endtask

    task automatic test_good_frame();
        beats.delete();
        build_frame(60, 1'b1, 1'b0);
        send_frame(-1);
        idle(4);
        exp_ok++;
        check_frame("good", 60, 1'b0);
    endtask

    task automatic test_fcs_corrupt();
        beats.delete();
        build_frame(60, 1'b1, 1'b1);
        send_frame(-1);
        idle(4);
        exp_crc++;
        check_frame("fcs_corrupt", 60, 1'b1);
    endtask

    task automatic test_paced();
        int gaps = 0;
        beats.delete();
        build_frame(60, 1'b1, 1'b0);
        pace = 5;
        send_frame(-1);
        pace = 1;
        idle(6);
        exp_ok++;
        check_frame("paced", 60, 1'b0);
        for (int i = 1; i < beats.size(); i++)
            if (beats[i].cycle - beats[i-1].cycle != 5) gaps++;
        checks++;
        if (gaps != 0 || beats.size() < 2) begin
            errors++;
            $display("FAIL paced_spacing: got %0d wrong gaps over %0d beats expected 0", gaps, beats.size());
        end
    endtask

    task automatic test_runt();
        beats.delete();
        build_frame(20, 1'b1, 1'b0);
        send_frame(-1);
        idle(4);
        exp_bad++;
        check_frame("runt", 20, 1'b1);
    endtask

    task automatic test_short();
        beats.delete();
        build_frame(3, 1'b0, 1'b0);
        send_frame(-1);
        idle(4);
        exp_bad++;
        check_frame("short3", 0, 1'b1);
    endtask

    task automatic test_rx_er();
        beats.delete();
        build_frame(60, 1'b1, 1'b0);
        send_frame(10);
        idle(4);
        exp_bad++;
        check_frame("rx_er", 60, 1'b1);
    endtask

    task automatic test_oversize();
        beats.delete();
        build_frame(1600, 1'b0, 1'b0);
        send_frame(-1);
        idle(4);
        exp_bad++;
        // Bytes 1..1513 stream out, byte 1514 closes the frame when byte 1519 arrives.
        check_frame("oversize", 1514, 1'b1);
    endtask

    task automatic test_preamble_errors();
        beats.delete();
        // Bad byte inside the preamble.
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h12, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'hD5, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        // Frame starting with something other than 55.
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(i), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        // rx_er during preamble.
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h55, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        // Carrier drops during preamble: silent.
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        idle(4);
        exp_bad = exp_bad + 3;
        check_frame("preamble_err", 0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        int lasts = 0;
        beats.delete();
        build_frame(60, 1'b1, 1'b0);
        send_preamble();
        for (int i = 0; i < 30; i++) drive(1'b1, frm[i], 1'b0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_last, m_error, m_data} !== 11'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 0", {m_valid, m_last, m_error, m_data});
        end
        checks++;
        if ({frames_ok, frames_crc_err, frames_bad} !== {CW*3{1'b0}}) begin
            errors++;
            $display("FAIL midreset_counters: got ok=%0d crc=%0d bad=%0d expected 0/0/0",
                     frames_ok, frames_crc_err, frames_bad);
        end
        foreach (beats[i]) if (beats[i].last !== 1'b0) lasts++;
        checks++;
        if (beats.size() != 24 || lasts != 0) begin
            errors++;
            $display("FAIL midreset_partial: got %0d beats %0d last expected 24 beats 0 last",
                     beats.size(), lasts);
        end
        exp_ok = '0; exp_crc = '0; exp_bad = '0;
        rx_en = 1'b0; rx_dv = 1'b0; rx_er = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        beats.delete();
        send_frame(-1);
        idle(4);
        exp_ok++;
        check_frame("after_reset", 60, 1'b0);
    endtask

    task automatic test_back_to_back();
        int se;
        beats.delete();
        build_frame(60, 1'b1, 1'b0);
        send_frame(-1);
        send_frame(-1);
        idle(4);
        exp_ok = exp_ok + 2;
        checks++;
        if (beats.size() != 120) begin
            errors++;
            $display("FAIL b2b_beats: got %0d expected 120", beats.size());
        end
        se = seq_errs(0, 60) + seq_errs(60, 60);
        checks++;
        if (se != 0) begin
            errors++;
            $display("FAIL b2b_sequence: got %0d bad beats expected 0", se);
        end
        checks++;
        if (beat_err(59) !== 1'b0 || beat_err(119) !== 1'b0) begin
            errors++;
            $display("FAIL b2b_last_error: got %b/%b expected 0/0", beat_err(59), beat_err(119));
        end
        checks++;
        if ({frames_ok, frames_crc_err, frames_bad} !== {exp_ok, exp_crc, exp_bad}) begin
            errors++;
            $display("FAIL b2b_counters: got ok=%0d crc=%0d bad=%0d expected ok=%0d crc=%0d bad=%0d",
                     frames_ok, frames_crc_err, frames_bad, exp_ok, exp_crc, exp_bad);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_fcs_corrupt();
        test_paced();
        test_runt();
        test_short();
        test_rx_er();
        test_oversize();
        test_preamble_errors();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
